// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead add/sub: stage-count
// functions and the per-group propagate/generate/carry lookahead.
package cla_pkg;

    localparam int GRP_MAX = 8;

    typedef struct packed {
        logic       gs;
        logic       ps;
        logic [7:0] c;
    } grp_la_t;

    function automatic int ng(input int width, input int grp);
        return width / grp;
    endfunction

    function automatic int lat(input int width, input int grp);
        return ng(width, grp) + 3;
    endfunction

    // c[i] is the carry into bit i given cin; only the low n bits are meaningful.
    function automatic grp_la_t grp_la(input logic [7:0] p, input logic [7:0] g,
                                       input logic cin, input int n);
        grp_la_t r;
        logic    cy;
        r.gs = 1'b0;
        r.ps = 1'b1;
        r.c  = '0;
        cy   = cin;
        for (int i = 0; i < GRP_MAX; i++) begin
            if (i < n) begin
                r.c[i] = cy;
                cy     = g[i] | (p[i] & cy);
                r.gs   = g[i] | (p[i] & r.gs);
                r.ps   = r.ps & p[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_grp.sv
// Combinational lookahead for one GRP-bit slice: group generate/propagate
// plus the carries into each bit of the slice for a given group carry-in.
module cla_grp
    import cla_pkg::*;
#(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] p,
    input  logic [GRP-1:0] g,
    input  logic           cin,
    output logic           gs,
    output logic           ps,
    output logic [GRP-1:0] c
);
    grp_la_t la;
    logic    unused_hi;

    assign la = grp_la(8'(p), 8'(g), cin, GRP);
    assign gs = la.gs;
    assign ps = la.ps;
    assign c  = la.c[GRP-1:0];
    // carries above GRP are always zero
    assign unused_hi = ^la.c;

endmodule

// File: rtl/pp_cla_addsub.sv
// Fully pipelined carry-lookahead adder/subtractor, one group carry resolved
// per stage, with a global stall driven by output back-pressure.
module pp_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NG  = ng(WIDTH, GRP);
    localparam int LAT = lat(WIDTH, GRP);

    if (WIDTH % GRP != 0 || GRP < 2 || GRP > GRP_MAX) begin : g_bad_cfg
        $error("pp_cla_addsub: WIDTH must be a multiple of GRP and GRP must lie in 2..8");
    end

    logic           stall, en;
    logic [LAT:0]   vld_pipe;

    assign out_valid = vld_pipe[LAT];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign en        = ~stall;

    // vld_pipe[0] = S0, [2+j] = ripple stage j, [LAT-1] = sum stage, [LAT] = output
    always_ff @(posedge clk) begin
        if (rst)     vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[LAT-1:0], in_valid};
    end

    logic [WIDTH-1:0] a0, b0, p1, g1;
    logic             cin0, sub0, c1;

    always_ff @(posedge clk) begin
        if (en) begin
            a0   <= a;
            b0   <= b;
            cin0 <= cin;
            sub0 <= sub;
            p1   <= a0 ^ (b0 ^ {WIDTH{sub0}});
            g1   <= a0 & (b0 ^ {WIDTH{sub0}});
            c1   <= cin0 ^ sub0;
        end
    end

    // Intra-group carries assuming a zero group carry-in; fixed up at the sum stage.
    logic [NG-1:0]    gs_w, ps_w;
    logic [WIDTH-1:0] c0_w;

    cla_grp #(.GRP(GRP)) u_grp [NG-1:0] (
        .p  (p1),
        .g  (g1),
        .cin(1'b0),
        .gs (gs_w),
        .ps (ps_w),
        .c  (c0_w)
    );

    // Stage j knows the carries into groups 0..j; gs/ps shrink as groups resolve.
    for (genvar j = 0; j < NG; j++) begin : rip
        logic [WIDTH-1:0] p_q, c0_q;
        logic [j:0]       c_q;
        logic [NG-1:j]    gs_q, ps_q;

        if (j == 0) begin : ld
            always_ff @(posedge clk) begin
                if (en) begin
                    p_q  <= p1;
                    c0_q <= c0_w;
                    c_q  <= c1;
                    gs_q <= gs_w;
                    ps_q <= ps_w;
                end
            end
        end else begin : ld
            always_ff @(posedge clk) begin
                if (en) begin
                    p_q  <= rip[j-1].p_q;
                    c0_q <= rip[j-1].c0_q;
                    c_q  <= {rip[j-1].gs_q[j-1] | (rip[j-1].ps_q[j-1] & rip[j-1].c_q[j-1]),
                             rip[j-1].c_q};
                    gs_q <= rip[j-1].gs_q[NG-1:j];
                    ps_q <= rip[j-1].ps_q[NG-1:j];
                end
            end
        end
    end

    logic [WIDTH-1:0] p_f, c0_f, carry;
    logic [NG:0]      cg_f;
    logic             pp;

    always_ff @(posedge clk) begin
        if (en) begin
            p_f  <= rip[NG-1].p_q;
            c0_f <= rip[NG-1].c0_q;
            cg_f <= {rip[NG-1].gs_q[NG-1] | (rip[NG-1].ps_q[NG-1] & rip[NG-1].c_q[NG-1]),
                     rip[NG-1].c_q};
        end
    end

    // Real carry into each bit: local carry, or the group carry-in propagated up to it.
    always_comb begin
        carry = '0;
        pp    = 1'b0;
        for (int k = 0; k < NG; k++) begin
            pp = 1'b1;
            for (int i = 0; i < GRP; i++) begin
                carry[k*GRP+i] = c0_f[k*GRP+i] | (pp & cg_f[k]);
                pp             = pp & p_f[k*GRP+i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (en && vld_pipe[LAT-1]) begin
            s    <= p_f ^ carry;
            cout <= cg_f[NG];
            ovf  <= carry[WIDTH-1] ^ cg_f[NG];
        end
    end

endmodule

// File: tb/tb_pp_cla_addsub.sv
// Directed vector table plus hand-written flow-control and reset sequences,
// and a short random run checked against a scoreboard.
module tb_pp_cla_addsub;
    localparam int W   = 16;
    localparam int LAT = 7;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;
    int           n_chk = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    pp_cla_addsub #(.WIDTH(W), .GRP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        cout, ovf;
    } vec_t;

    vec_t        vecs[12];
    logic [17:0] q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_beat(input int i);
        a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
        in_valid = 1'b1;
    endtask

    // one isolated beat: latency and result
    task automatic run_one(input int i);
        int k;
        set_beat(i);
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < LAT + 4) begin
            tick();
            k++;
        end
        chk($sformatf("latency[%0d]", i), k, LAT);
        chk($sformatf("s[%0d]", i), s, vecs[i].s);
        chk($sformatf("cout[%0d]", i), cout, vecs[i].cout);
        chk($sformatf("ovf[%0d]", i), ovf, vecs[i].ovf);
        tick();
    endtask

    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] be;
        logic [16:0] r;
        logic        o;
        be = ms ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, be} + 17'(mc ^ ms);
        o  = (ma[15] == be[15]) && (r[15] != ma[15]);
        return {o, r[16], r[15:0]};
    endfunction

    task automatic try_pop(input string name);
        logic [17:0] e;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk({name, "_spurious"}, 1, 0);
            else begin
                e = q.pop_front();
                chk(name, {14'b0, ovf, cout, s}, {14'b0, e});
            end
        end
    endtask

    initial begin
        int saw;
        vecs[0]  = '{16'h55F5, 16'h5448, 1'b0, 1'b0, 16'hAA3D, 1'b0, 1'b1};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[5]  = '{16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
        vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
        vecs[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[11] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_one(i);

        // three back-to-back beats, results on consecutive cycles
        for (int i = 0; i < 3; i++) begin set_beat(i); tick(); end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("tp_not_early", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("tp_valid[%0d]", i), out_valid, 1);
            chk($sformatf("tp_s[%0d]", i), s, vecs[i].s);
        end
        tick();
        chk("tp_done", out_valid, 0);

        // hold out_ready low for 3 cycles while the first result is shown
        for (int i = 3; i < 6; i++) begin set_beat(i); tick(); end
        in_valid = 1'b0;
        repeat (5) tick();
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_s", s, vecs[3].s);
        out_ready = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("bp_in_ready[%0d]", r), in_ready, 0);
            chk($sformatf("bp_hold_s[%0d]", r), s, vecs[3].s);
            tick();
        end
        chk("bp_still_valid", out_valid, 1);
        chk("bp_still_s", s, vecs[3].s);
        out_ready = 1'b1;
        tick();
        chk("bp_second_s", s, vecs[4].s);
        chk("bp_second_valid", out_valid, 1);
        tick();
        chk("bp_third_s", s, vecs[5].s);
        tick();
        chk("bp_done", out_valid, 0);

        // reset with 4 beats in flight while stalled
        for (int i = 6; i < 10; i++) begin set_beat(i); tick(); end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("rm_pre_valid", out_valid, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rm_out_valid", out_valid, 0);
        chk("rm_s", s, 0);
        chk("rm_in_ready", in_ready, 1);
        saw = 0;
        repeat (12) begin tick(); if (out_valid) saw = 1; end
        chk("rm_no_stale", saw, 0);
        run_one(10);

        // random traffic with random back-pressure
        for (int c = 0; c < 400; c++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            try_pop("rnd");
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            try_pop("drain");
            tick();
        end
        chk("rnd_all_out", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
